// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
// Bit timing (TICKS+1 clocks per bit) matches the team transmitter.
module uart_rx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TICKS = CLK_FREQ / BAUD_RATE;
  localparam int BIT   = TICKS + 1;
  localparam int HALF  = BIT / 2;
  localparam int CW    = $clog2(BIT + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  if (TICKS < 4) begin : g_ticks_check
    $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  logic [1:0]    sync_q;
  logic          rx_s;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          frame_err_q;
  logic          busy_q;

  // Two-flop synchronizer; the line idles high, so reset to 1 avoids a false start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments so each flop samples the pre-edge value of its neighbour.
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle; the branches below only raise them.
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          // Re-check the line half a bit in so short glitches are ignored.
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= rx_s;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        STOP: begin
          // Leaving at mid-stop lets a back-to-back start edge be caught.
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        WAIT_HIGH: begin
          if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a frame-level scoreboard predicts each
// valid/frame_err pulse, its byte and its due cycle; directed tests add literals.
module tb_uart_rx;

  localparam int CLK_FREQ  = 16;
  localparam int BAUD_RATE = 1;
  localparam int BIT       = CLK_FREQ / BAUD_RATE + 1;
  localparam int HALF      = BIT / 2;
  localparam int LAT       = 2 + HALF + 9 * BIT;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input bit ok, input int act, input int exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  typedef struct {
    bit         is_err;
    logic [7:0] val;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_data = 8'h00;
  int         n_valid = 0;
  int         n_err = 0;
  int         valid_cycs[$];

  // Scoreboard: every pulse must match the oldest predicted frame within +/-1
  // clock, and data must equal the last correctly received byte on every cycle.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (rst) begin
      model_data = 8'h00;
      exp_q.delete();
    end else begin
      if (valid || frame_err) begin
        check("valid_xor_frame_err", !(valid && frame_err), {valid, frame_err}, 0);
        check("pulse_expected", exp_q.size() > 0, exp_q.size(), 1);
        if (valid) begin
          n_valid++;
          valid_cycs.push_back(cyc);
        end
        if (frame_err) n_err++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pulse_kind_is_valid", valid == !e.is_err, valid, !e.is_err);
          check("pulse_time", (cyc >= e.due - 1) && (cyc <= e.due + 1), cyc, e.due);
          if (!e.is_err) model_data = e.val;
        end
      end
      check("data", data == model_data, data, model_data);
      if (exp_q.size() > 0 && cyc > exp_q[0].due + 1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pulse_missing: got none by cycle %0d, want one at %0d", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  // Hold the line at lvl for n clock edges; always ends #1 after an edge.
  task automatic line(input logic lvl, input int n);
    rx = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] v, input logic stop_lvl, output int start_cyc);
    start_cyc = cyc;
    exp_q.push_back('{is_err: !stop_lvl, val: v, due: cyc + 1 + LAT});
    line(1'b0, BIT);
    for (int i = 0; i < 8; i++) line(v[i], BIT);
    line(stop_lvl, BIT);
  endtask

  int k, k2, first_hi, last_hi, n_hi, waited, nv0, ne0;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", data == 8'h00, data, 8'h00);
    check("reset_valid", valid == 1'b0, valid, 0);
    check("reset_frame_err", frame_err == 1'b0, frame_err, 0);
    check("reset_busy", busy == 1'b0, busy, 0);
    rst = 1'b0;
    line(1'b1, BIT);

    // Loopback of 8'hA5.
    nv0 = n_valid; ne0 = n_err;
    send_frame(8'hA5, 1'b1, k);
    line(1'b1, 4);
    check("a5_data", data == 8'hA5, data, 8'hA5);
    check("a5_one_valid", n_valid - nv0 == 1, n_valid - nv0, 1);
    check("a5_no_frame_err", n_err == ne0, n_err - ne0, 0);
    check("a5_latency", valid_cycs[$] - k >= 161 && valid_cycs[$] - k <= 165, valid_cycs[$] - k, 163);

    // Bit order with 8'h01; busy must stay high from detection to valid.
    k = cyc; first_hi = -1; last_hi = -1; n_hi = 0;
    fork
      send_frame(8'h01, 1'b1, k2);
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (busy) begin
          if (first_hi < 0) first_hi = cyc;
          last_hi = cyc;
          n_hi++;
        end
      end
    join
    @(posedge clk);
    #1;
    check("b01_data", data == 8'h01, data, 8'h01);
    check("b01_busy_rise", first_hi == k + 3, first_hi - k, 3);
    check("b01_busy_fall", last_hi + 1 == valid_cycs[$], last_hi + 1, valid_cycs[$]);
    check("b01_busy_steady", n_hi == last_hi - first_hi + 1, n_hi, last_hi - first_hi + 1);
    line(1'b1, BIT);

    // Glitch of 4 clocks, then 8'h3C.
    nv0 = n_valid; ne0 = n_err;
    line(1'b0, 4);
    check("glitch_detected_busy", busy == 1'b1, busy, 1);
    waited = 0;
    while (busy && waited < HALF + 8) begin
      line(1'b1, 1);
      waited++;
    end
    check("glitch_busy_clear", !busy && waited <= HALF + 3, waited, HALF + 3);
    line(1'b1, BIT);
    check("glitch_no_pulse", (n_valid == nv0) && (n_err == ne0), n_valid + n_err - nv0 - ne0, 0);
    send_frame(8'h3C, 1'b1, k);
    line(1'b1, 4);
    check("c3c_data", data == 8'h3C, data, 8'h3C);

    // Framing error: 8'h55 with stop low and line held low 3*BIT.
    nv0 = n_valid; ne0 = n_err;
    send_frame(8'h55, 1'b0, k);
    line(1'b0, 2 * BIT);
    check("ferr_one_pulse", n_err - ne0 == 1, n_err - ne0, 1);
    check("ferr_no_valid", n_valid == nv0, n_valid - nv0, 0);
    check("ferr_data_kept", data == 8'h3C, data, 8'h3C);
    check("ferr_busy_while_low", busy == 1'b1, busy, 1);
    line(1'b1, 4);
    check("ferr_busy_after_high", busy == 1'b0, busy, 0);
    check("ferr_still_one_pulse", n_err - ne0 == 1, n_err - ne0, 1);
    line(1'b1, BIT);
    send_frame(8'hC3, 1'b1, k);
    line(1'b1, 4);
    check("cc3_data", data == 8'hC3, data, 8'hC3);
    line(1'b1, BIT);

    // Back-to-back 8'h00 then 8'hFF, no idle gap.
    nv0 = n_valid;
    send_frame(8'h00, 1'b1, k);
    send_frame(8'hFF, 1'b1, k2);
    line(1'b1, 4);
    check("b2b_two_valid", n_valid - nv0 == 2, n_valid - nv0, 2);
    check("b2b_data", data == 8'hFF, data, 8'hFF);
    check("b2b_spacing", valid_cycs[$] - valid_cycs[$-1] == 170, valid_cycs[$] - valid_cycs[$-1], 170);
    line(1'b1, BIT);

    // Reset during bit 4 of 8'h96.
    nv0 = n_valid;
    begin
      logic [7:0] v;
      v = 8'h96;
      line(1'b0, BIT);
      for (int i = 0; i < 4; i++) line(v[i], BIT);
      line(v[4], HALF);
    end
    check("pre_reset_busy", busy == 1'b1, busy, 1);
    rst = 1'b1;
    #1;
    check("mid_reset_data", data == 8'h00, data, 8'h00);
    check("mid_reset_busy", busy == 1'b0, busy, 0);
    check("mid_reset_pulses", (valid == 1'b0) && (frame_err == 1'b0), {valid, frame_err}, 0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    line(1'b1, 2 * BIT);
    check("post_reset_no_valid", n_valid == nv0, n_valid - nv0, 0);
    send_frame(8'h96, 1'b1, k);
    line(1'b1, 4);
    check("r96_data", data == 8'h96, data, 8'h96);
    check("r96_one_valid", n_valid - nv0 == 1, n_valid - nv0, 1);

    line(1'b1, 2 * BIT);
    check("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
